traffic_timer: RTL and testbench



---
 rtl/traffic_timer.sv | 119 +++++++++++
 tb/tb_traffic_timer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_timer.sv
// traffic_timer: interval timer beside the traffic controller; ST restarts,
// TS/TL flag short/long interval, Hold freezes. Optional: TRAFFIC_TIMER_COUNTDOWN_EN.
//
// Ports:
//   Clk    in   system clock, rising edge
//   reset  in   asynchronous, active-low reset
//   ST     in   start/restart request (any cycle high restarts)
//   Hold   in   freeze prescaler and tick counter while running
//   TS     out  short interval elapsed (registered level)
//   TL     out  long interval elapsed (registered level)
//   Busy   out  timing in progress
//   Remain out  ticks left to the next flag (only with TRAFFIC_TIMER_COUNTDOWN_EN)
module traffic_timer #(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned SHORT_SEC = 5,
    parameter int unsigned LONG_SEC  = 25,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             ST,
    input  logic             Hold,
    output logic             TS,
    output logic             TL,
`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
    output logic [CNT_W-1:0] Remain,
`endif
    output logic             Busy
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] SEC_S   = CNT_W'(SHORT_SEC);
    localparam logic [CNT_W-1:0] SEC_L   = CNT_W'(LONG_SEC);

    // Elaboration-time guard on the interval parameters.
    if (SHORT_SEC >= LONG_SEC || (LONG_SEC >> CNT_W) != 0) begin : g_param_err
        $error("traffic_timer: need SHORT_SEC < LONG_SEC < 2**CNT_W");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [PRE_W-1:0] r_pre;
    logic [CNT_W-1:0] r_sec;
    logic             r_ts;
    logic             r_tl;

    state_t           w_state;
    logic [PRE_W-1:0] w_pre;
    logic [CNT_W-1:0] w_sec;
    logic             w_ts;
    logic             w_tl;
    logic [CNT_W-1:0] w_sec_inc;

    assign w_sec_inc = r_sec + 1'b1;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_sec   <= '0;
            r_ts    <= 1'b0;
            r_tl    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pre   <= w_pre;
            r_sec   <= w_sec;
            r_ts    <= w_ts;
            r_tl    <= w_tl;
        end
    end

    always_comb begin
        w_state = r_state;
        w_pre   = r_pre;
        w_sec   = r_sec;
        w_ts    = r_ts;
        w_tl    = r_tl;
        if (ST) begin
            // Restart beats both Hold and a simultaneous tick wrap.
            w_state = S_RUN;
            w_pre   = '0;
            w_sec   = '0;
            w_ts    = 1'b0;
            w_tl    = 1'b0;
        end else if (r_state == S_RUN && !Hold) begin
            if (r_pre == PRE_MAX) begin
                w_pre = '0;
                w_sec = w_sec_inc;
                if (w_sec_inc == SEC_S) begin
                    w_ts = 1'b1;
                end
                // Leaving RUN here keeps sec saturated at LONG_SEC.
                if (w_sec_inc == SEC_L) begin
                    w_tl    = 1'b1;
                    w_state = S_DONE;
                end
            end else begin
                w_pre = r_pre + 1'b1;
            end
        end
    end

    assign TS   = r_ts;
    assign TL   = r_tl;
    assign Busy = (r_state == S_RUN);

`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
    // Follows sec directly, so it changes on the same edge as the count.
    assign Remain = (r_state == S_RUN) ? ((r_ts ? SEC_L : SEC_S) - r_sec) : '0;
`endif

endmodule

// File: tb/tb_traffic_timer.sv
// tb_traffic_timer: segment table for the directed scenarios, hand-written
// reset sequences, and random ST/Hold against an elapsed-cycle model.
module tb_traffic_timer;

    localparam int DIV = 4;
    localparam int SS  = 2;
    localparam int LS  = 5;
    localparam int CW  = 8;

    logic Clk;
    logic reset;
    logic ST;
    logic Hold;
    logic TS;
    logic TL;
    logic Busy;
`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
    logic [CW-1:0] Remain;
`endif

    traffic_timer #(
        .TICK_DIV (DIV),
        .SHORT_SEC(SS),
        .LONG_SEC (LS),
        .CNT_W    (CW)
    ) dut (
        .Clk   (Clk),
        .reset (reset),
        .ST    (ST),
        .Hold  (Hold),
        .TS    (TS),
        .TL    (TL),
`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
        .Remain(Remain),
`endif
        .Busy  (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_err    = 0;

    // Model: whether a run was ever started since reset, and how many
    // un-held, non-restart edges have elapsed since the last ST.
    bit m_started;
    int m_n;

    typedef struct {
        int       n;
        bit       st;
        bit       hold;
        bit [2:0] exp;
    } seg_t;

    seg_t tbl[$];

    function automatic bit [2:0] model_out();
        bit ts;
        bit tl;
        bit bz;
        ts = m_started && (m_n >= SS * DIV);
        tl = m_started && (m_n >= LS * DIV);
        bz = m_started && (m_n < LS * DIV);
        return {ts, tl, bz};
    endfunction

    task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: {TS,TL,Busy}=%b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
    task automatic chk_remain(input string nm);
        bit [2:0] o;
        int       e;
        o = model_out();
        e = o[0] ? ((o[2] ? LS : SS) - m_n / DIV) : 0;
        n_checks++;
        if (Remain !== CW'(e)) begin
            n_err++;
            $display("FAIL %s: Remain=%0d expected %0d at %0t", nm, Remain, e, $time);
        end
    endtask
`endif

    // Drive inputs, take one edge, advance the model, sample 1 ns later.
    task automatic step(input bit st, input bit hold);
        ST   = st;
        Hold = hold;
        @(posedge Clk);
        if (st) begin
            m_started = 1'b1;
            m_n       = 0;
        end else if (m_started && !hold && m_n < LS * DIV) begin
            m_n++;
        end
        #1;
    endtask

    initial begin
        bit [2:0] w_exp;

        tbl.push_back('{1, 1'b1, 1'b0, 3'b001});
        tbl.push_back('{7, 1'b0, 1'b0, 3'b001});
        tbl.push_back('{12, 1'b0, 1'b0, 3'b101});
        tbl.push_back('{11, 1'b0, 1'b0, 3'b110});
        tbl.push_back('{3, 1'b0, 1'b1, 3'b110});
        tbl.push_back('{1, 1'b1, 1'b1, 3'b001});
        tbl.push_back('{2, 1'b0, 1'b1, 3'b001});
        tbl.push_back('{2, 1'b0, 1'b0, 3'b001});
        tbl.push_back('{6, 1'b0, 1'b1, 3'b001});
        tbl.push_back('{5, 1'b0, 1'b0, 3'b001});
        tbl.push_back('{12, 1'b0, 1'b0, 3'b101});
        tbl.push_back('{2, 1'b0, 1'b0, 3'b110});
        tbl.push_back('{1, 1'b1, 1'b0, 3'b001});
        tbl.push_back('{7, 1'b0, 1'b0, 3'b001});
        tbl.push_back('{4, 1'b0, 1'b0, 3'b101});
        tbl.push_back('{1, 1'b1, 1'b0, 3'b001});
        tbl.push_back('{7, 1'b0, 1'b0, 3'b001});
        tbl.push_back('{12, 1'b0, 1'b0, 3'b101});
        tbl.push_back('{1, 1'b0, 1'b0, 3'b110});
        tbl.push_back('{1, 1'b1, 1'b0, 3'b001});
        tbl.push_back('{3, 1'b0, 1'b0, 3'b001});
        tbl.push_back('{1, 1'b1, 1'b0, 3'b001});
        tbl.push_back('{7, 1'b0, 1'b0, 3'b001});
        tbl.push_back('{1, 1'b0, 1'b0, 3'b101});
        tbl.push_back('{3, 1'b1, 1'b0, 3'b001});
        tbl.push_back('{7, 1'b0, 1'b0, 3'b001});
        tbl.push_back('{1, 1'b0, 1'b0, 3'b101});

        m_started = 1'b0;
        m_n       = 0;
        reset     = 1'b0;
        ST        = 1'b0;
        Hold      = 1'b0;

        repeat (2) @(posedge Clk);
        #1;
        chk("reset_state", {TS, TL, Busy}, 3'b000);
        @(negedge Clk);
        reset = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step(1'b0, i[0]);
            chk("idle_wait", {TS, TL, Busy}, 3'b000);
        end

        for (int s = 0; s < tbl.size(); s++) begin
            for (int c = 0; c < tbl[s].n; c++) begin
                step(tbl[s].st, tbl[s].hold);
                chk($sformatf("seg%0d_cyc%0d", s, c), {TS, TL, Busy}, tbl[s].exp);
`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
                chk_remain($sformatf("seg%0d_remain", s));
`endif
            end
        end

`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
        step(1'b1, 1'b0);
        n_checks++;
        if (Remain !== 8'd2) begin
            n_err++;
            $display("FAIL remain_start: Remain=%0d expected 2", Remain);
        end
        repeat (4) step(1'b0, 1'b0);
        n_checks++;
        if (Remain !== 8'd1) begin
            n_err++;
            $display("FAIL remain_k4: Remain=%0d expected 1", Remain);
        end
        repeat (4) step(1'b0, 1'b0);
        n_checks++;
        if (Remain !== 8'd3) begin
            n_err++;
            $display("FAIL remain_k8: Remain=%0d expected 3", Remain);
        end
        repeat (12) step(1'b0, 1'b0);
        n_checks++;
        if (Remain !== 8'd0) begin
            n_err++;
            $display("FAIL remain_done: Remain=%0d expected 0", Remain);
        end
`endif

        // Asynchronous reset with sec=3, between edges.
        step(1'b1, 1'b0);
        repeat (13) step(1'b0, 1'b0);
        chk("pre_abort", {TS, TL, Busy}, 3'b101);
        #2;
        reset = 1'b0;
        #1;
        chk("async_abort", {TS, TL, Busy}, 3'b000);
`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
        m_started = 1'b0;
        chk_remain("async_remain");
`endif
        m_started = 1'b0;
        m_n       = 0;
        @(negedge Clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0);
            chk("idle_after_rst", {TS, TL, Busy}, 3'b000);
        end

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
            w_exp = model_out();
            chk("random", {TS, TL, Busy}, w_exp);
`ifdef TRAFFIC_TIMER_COUNTDOWN_EN
            chk_remain("random_remain");
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
